// File: rtl/screen_reset_out_if.sv
// Avalon-MM slave bus bundle for the screen reset output port.
interface screen_reset_out_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/screen_reset_out.sv
// Memory-mapped output port driving the screen reset line: a static level
// plus a one-shot pulse of exact cycle length, followed by a low hold-off
// window, with a sticky completion flag and a maskable level interrupt.
module screen_reset_out #(
    parameter int COUNT_W = 24,
    parameter int HOLDOFF = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    screen_reset_out_if.slave   bus,
    output logic                out_port,
    output logic                irq
);

    // Counter must hold both the longest pulse and the hold-off length.
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int CW   = (COUNT_W > HO_W) ? COUNT_W : HO_W;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [COUNT_W-1:0] len_q;
    logic               level;
    logic               done;
    logic               irq_en;

    logic wr;
    logic wr_ctrl;
    logic start_ok;
    logic busy;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign wr_ctrl  = wr & (bus.address == 2'd2);
    // A zero-length start is dropped outright; the FSM never sees it.
    assign start_ok = wr_ctrl & bus.writedata[0] & (len_q != '0);
    assign busy     = (state != IDLE);

    // Both terms come straight from flops, so the OR cannot glitch.
    assign out_port = level | (state == PULSE);
    assign irq      = done & irq_en;

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level  <= 1'b0;
            len_q  <= '0;
            irq_en <= 1'b0;
        end else if (wr) begin
            case (bus.address)
                2'd0:    level  <= bus.writedata[0];
                2'd1:    len_q  <= bus.writedata[COUNT_W-1:0];
                2'd3:    irq_en <= bus.writedata[0];
                default: ;
            endcase
        end
    end

    // Pulse/hold-off sequencer. The final cycle of the previous window
    // accepts a new start, so restarts can be issued back to back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            // Clear first so a completion in the same cycle overrides it.
            if (wr_ctrl && bus.writedata[1])
                done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cnt   <= CW'(len_q);
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == CNT_ONE) begin
                        done <= 1'b1;
                        if (HOLDOFF != 0) begin
                            cnt   <= HOLD_LOAD;
                            state <= HOLD;
                        end else if (start_ok) begin
                            cnt   <= CW'(len_q);
                            state <= PULSE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_ONE) begin
                        if (start_ok) begin
                            cnt   <= CW'(len_q);
                            state <= PULSE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux registered every cycle from address; no read strobe needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                2'd0:    bus.readdata <= {31'b0, out_port};
                2'd1:    bus.readdata <= 32'(len_q);
                2'd2:    bus.readdata <= {30'b0, done, busy};
                default: bus.readdata <= {31'b0, irq_en};
            endcase
        end
    end

endmodule

// File: tb/tb_screen_reset_out.sv
// Bench for screen_reset_out: a default build (COUNT_W=24, HOLDOFF=16) and a
// small build (COUNT_W=4, HOLDOFF=0), each tracked by a timeline model that
// predicts outputs from start edges, pulse lengths and window ends.
module tb_screen_reset_out;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    screen_reset_out_if b0 ();
    screen_reset_out_if b1 ();
    logic out0, irq0, out1, irq1;

    screen_reset_out #(.COUNT_W(24), .HOLDOFF(16)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0.slave), .out_port(out0), .irq(irq0));
    screen_reset_out #(.COUNT_W(4), .HOLDOFF(0)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave), .out_port(out1), .irq(irq1));

    int checks = 0;
    int passes = 0;

    logic        o_act [2];
    logic        q_act [2];
    logic [31:0] r_act [2];
    logic        wr_s  [2];
    logic [1:0]  a_s   [2];
    logic [31:0] d_s   [2];

    assign o_act[0] = out0;
    assign o_act[1] = out1;
    assign q_act[0] = irq0;
    assign q_act[1] = irq1;
    assign r_act[0] = b0.readdata;
    assign r_act[1] = b1.readdata;
    assign wr_s[0]  = b0.chipselect & ~b0.write_n;
    assign wr_s[1]  = b1.chipselect & ~b1.write_n;
    assign a_s[0]   = b0.address;
    assign a_s[1]   = b1.address;
    assign d_s[0]   = b0.writedata;
    assign d_s[1]   = b1.writedata;

    // ---------------- reference model: timeline of edges ----------------
    int          cyc = 0;
    bit          m_level [2];
    bit          m_done  [2];
    bit          m_irqen [2];
    int          m_len   [2];
    int          pstart  [2];   // edge index of the accepted start
    int          plen    [2];   // length of that pulse
    int          bend    [2];   // edge after which the port is idle again
    int          dedge   [2];   // edge at which done is set
    logic [31:0] m_rd    [2];

    function automatic int ho(input int i);
        return (i == 0) ? 16 : 0;
    endfunction

    function automatic logic [31:0] lmask(input int i);
        return (i == 0) ? 32'h00FF_FFFF : 32'h0000_000F;
    endfunction

    // Output high after edge c when c lies in [start, start+len).
    function automatic bit pulse_at(input int i, input int c);
        return (plen[i] != 0) && (c >= pstart[i]) && (c < pstart[i] + plen[i]);
    endfunction

    function automatic bit m_out(input int i);
        return m_level[i] | pulse_at(i, cyc);
    endfunction

    function automatic bit m_irq(input int i);
        return m_done[i] & m_irqen[i];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 0; m_done[i] = 0; m_irqen[i] = 0; m_len[i] = 0;
                pstart[i] = 0; plen[i] = 0; bend[i] = 0; dedge[i] = -1;
                m_rd[i] = '0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                case (a_s[i])
                    2'd0:    m_rd[i] = {31'b0, m_level[i] | pulse_at(i, cyc - 1)};
                    2'd1:    m_rd[i] = m_len[i];
                    2'd2:    m_rd[i] = {30'b0, m_done[i], (cyc - 1) < bend[i]};
                    default: m_rd[i] = {31'b0, m_irqen[i]};
                endcase
                if (wr_s[i]) begin
                    case (a_s[i])
                        2'd0:    m_level[i] = d_s[i][0];
                        2'd1:    m_len[i] = int'(d_s[i] & lmask(i));
                        2'd2:    if (d_s[i][1]) m_done[i] = 0;
                        default: m_irqen[i] = d_s[i][0];
                    endcase
                end
                if (dedge[i] == cyc) m_done[i] = 1;
                if (wr_s[i] && a_s[i] == 2'd2 && d_s[i][0] && m_len[i] != 0 && cyc >= bend[i]) begin
                    pstart[i] = cyc;
                    plen[i]   = m_len[i];
                    bend[i]   = cyc + m_len[i] + ho(i);
                    dedge[i]  = cyc + m_len[i];
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input int i, input bit w, input logic [1:0] a, input logic [31:0] d);
        logic cs;
        logic wn;
        cs = w ? 1'b1 : 1'($urandom_range(0, 1));
        wn = w ? 1'b0 : (cs ? 1'b1 : 1'($urandom_range(0, 1)));
        if (i == 0) begin
            b0.chipselect = cs; b0.write_n = wn; b0.address = a;
            b0.writedata = w ? d : $urandom();
        end else begin
            b1.chipselect = cs; b1.write_n = wn; b1.address = a;
            b1.writedata = w ? d : $urandom();
        end
    endtask

    task automatic wr_reg(input int i, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ia);
        drive(i, 1'b1, a, d);
        @(negedge clk);
        drive(i, 1'b0, ia, 32'h0);
    endtask

    function automatic logic [31:0] ctrl_word(input logic [1:0] bits);
        return ($urandom() & 32'hFFFF_FFFC) | {30'b0, bits};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int hi;
        drive(0, 1'b0, 2'd2, 0);
        drive(1, 1'b0, 2'd2, 0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({o_act[i], q_act[i], r_act[i]} !== 34'b0)
                $display("FAIL reset_state dut%0d got out=%b irq=%b rd=%h want all 0", i, o_act[i], q_act[i], r_act[i]);
            else passes++;
        end
        reset_n = 1'b1;
        wr_reg(0, 2'd1, 32'd100, 2'd2);
        wr_reg(0, 2'd3, 32'd1, 2'd2);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        hi = 0;
        for (int j = 0; j < 50; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL reset_prepulse cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            @(negedge clk);
        end
        checks++;
        if (hi !== 50) $display("FAIL reset_prepulse_high got %0d want 50", hi);
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out0, irq0, b0.readdata} !== 34'b0)
            $display("FAIL reset_async got out=%b irq=%b rd=%h want all 0", out0, irq0, b0.readdata);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 1'b0, 2'd2, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({o_act[0], r_act[0]} !== 33'b0)
            $display("FAIL reset_ctrl_after got out=%b rd=%h want 0/0", o_act[0], r_act[0]);
        else passes++;
    endtask

    task automatic test_basic();
        int hi, saw3, saw2;
        wr_reg(0, 2'd1, ($urandom() & 32'hFF00_0000) | 32'd5, 2'd2);
        wr_reg(0, 2'd3, 32'd1, 2'd2);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        hi = 0; saw3 = 0; saw2 = 0;
        for (int j = 0; j < 30; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL basic cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            if (r_act[0] == 32'h3) saw3++;
            if (r_act[0] == 32'h2 && saw3 != 0) saw2++;
            @(negedge clk);
        end
        checks++;
        if (hi !== 5 || saw3 !== 16 || saw2 == 0)
            $display("FAIL basic_width got high=%0d ctrl3=%0d ctrl2=%0d want 5/16/>0", hi, saw3, saw2);
        else passes++;
        checks++;
        if (irq0 !== 1'b1) $display("FAIL basic_irq_set got %b want 1", irq0);
        else passes++;
        wr_reg(0, 2'd2, ctrl_word(2'b10), 2'd2);
        checks++;
        if (irq0 !== 1'b0 || irq0 !== m_irq(0)) $display("FAIL basic_irq_clear got %b want 0", irq0);
        else passes++;
    endtask

    task automatic test_ignored();
        int hi, rises;
        logic prev;
        wr_reg(0, 2'd1, 32'd0, 2'd2);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        hi = 0;
        for (int j = 0; j < 6; j++) begin
            checks++;
            if ({o_act[0], r_act[0]} !== {m_out(0), m_rd[0]} || r_act[0][0] !== 1'b0)
                $display("FAIL ignored_len0 cyc=%0d got %b/%h want %b/%h", cyc, o_act[0], r_act[0], m_out(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            @(negedge clk);
        end
        wr_reg(0, 2'd1, 32'd10, 2'd2);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        prev = 1'b0;
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        rises = 0;
        for (int j = 0; j < 40; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL ignored_restart cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            if (o_act[0] && !prev) rises++;
            prev = o_act[0];
            if (j == 2 || j == 14) drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
            else drive(0, 1'b0, 2'd2, 0);
            @(negedge clk);
        end
        checks++;
        if (hi !== 10 || rises !== 1) $display("FAIL ignored_width got high=%0d rises=%0d want 10/1", hi, rises);
        else passes++;
    endtask

    task automatic test_len_change();
        int hi;
        wr_reg(0, 2'd1, 32'd8, 2'd1);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd1, 0);
        hi = 0;
        for (int j = 0; j < 30; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL lenchg_first cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            if (j == 1) drive(0, 1'b1, 2'd1, 32'd3);
            else drive(0, 1'b0, 2'd1, 0);
            @(negedge clk);
        end
        checks++;
        if (hi !== 8) $display("FAIL lenchg_width1 got %0d want 8", hi);
        else passes++;
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        hi = 0;
        for (int j = 0; j < 25; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL lenchg_second cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            @(negedge clk);
        end
        checks++;
        if (hi !== 3) $display("FAIL lenchg_width2 got %0d want 3", hi);
        else passes++;
    endtask

    task automatic test_level_overlap();
        int hi;
        wr_reg(0, 2'd2, ctrl_word(2'b10), 2'd0);
        wr_reg(0, 2'd0, ($urandom() & 32'hFFFF_FFFE) | 32'd1, 2'd0);
        wr_reg(0, 2'd1, 32'd4, 2'd0);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'($urandom_range(0, 3)), 0);
        hi = 0;
        for (int j = 0; j < 25; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL level_overlap cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            hi += o_act[0];
            drive(0, 1'b0, 2'($urandom_range(0, 3)), 0);
            @(negedge clk);
        end
        drive(0, 1'b0, 2'd2, 0);
        @(negedge clk);
        checks++;
        if (hi !== 25 || r_act[0] !== 32'h2) $display("FAIL level_done got high=%0d ctrl=%h want 25/2", hi, r_act[0]);
        else passes++;
        drive(0, 1'b0, 2'd0, 0);
        @(negedge clk);
        wr_reg(0, 2'd0, $urandom() & 32'hFFFF_FFFE, 2'd0);
        checks++;
        if (o_act[0] !== 1'b0 || r_act[0] !== 32'h1) $display("FAIL level_drop got out=%b rd=%h want 0/1", o_act[0], r_act[0]);
        else passes++;
        @(negedge clk);
        checks++;
        if (r_act[0] !== 32'h0) $display("FAIL level_readback got %h want 0", r_act[0]);
        else passes++;
    endtask

    task automatic test_simultaneous();
        logic irq_start, irq_end;
        wr_reg(0, 2'd1, 32'd6, 2'd2);
        drive(0, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        repeat (25) @(negedge clk);
        // done is set now; a combined start+clear clears it while starting
        drive(0, 1'b1, 2'd2, ctrl_word(2'b11));
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 0);
        irq_start = 1'b1; irq_end = 1'b0;
        for (int j = 0; j < 25; j++) begin
            checks++;
            if ({o_act[0], q_act[0], r_act[0]} !== {m_out(0), m_irq(0), m_rd[0]})
                $display("FAIL simul cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[0], q_act[0], r_act[0], m_out(0), m_irq(0), m_rd[0]);
            else passes++;
            if (j == 0) irq_start = q_act[0];
            if (j == 6) irq_end = q_act[0];
            if (j == 5) drive(0, 1'b1, 2'd2, ctrl_word(2'b10));
            else drive(0, 1'b0, 2'd2, 0);
            @(negedge clk);
        end
        checks++;
        if (irq_start !== 1'b0 || irq_end !== 1'b1)
            $display("FAIL simul_set_wins got irq_at_start=%b irq_at_end=%b want 0/1", irq_start, irq_end);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int hi, rises;
        logic prev;
        wr_reg(1, 2'd3, 32'd1, 2'd2);
        wr_reg(1, 2'd1, 32'd3, 2'd2);
        drive(1, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(1, 1'b0, 2'd2, 0);
        hi = 0; rises = 0; prev = 1'b0;
        for (int j = 0; j < 15; j++) begin
            checks++;
            if ({o_act[1], q_act[1], r_act[1]} !== {m_out(1), m_irq(1), m_rd[1]})
                $display("FAIL b2b cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[1], q_act[1], r_act[1], m_out(1), m_irq(1), m_rd[1]);
            else passes++;
            hi += o_act[1];
            if (o_act[1] && !prev) rises++;
            prev = o_act[1];
            if (j == 2) drive(1, 1'b1, 2'd2, ctrl_word(2'b01));
            else drive(1, 1'b0, 2'd2, 0);
            @(negedge clk);
        end
        checks++;
        if (hi !== 6 || rises !== 1) $display("FAIL b2b_width got high=%0d rises=%0d want 6/1", hi, rises);
        else passes++;
        wr_reg(1, 2'd1, 32'hFFFF_FFFF, 2'd1);
        drive(1, 1'b1, 2'd2, ctrl_word(2'b01));
        @(negedge clk);
        drive(1, 1'b0, 2'd2, 0);
        hi = 0;
        for (int j = 0; j < 25; j++) begin
            checks++;
            if ({o_act[1], q_act[1], r_act[1]} !== {m_out(1), m_irq(1), m_rd[1]})
                $display("FAIL maxlen cyc=%0d got %b/%b/%h want %b/%b/%h", cyc, o_act[1], q_act[1], r_act[1], m_out(1), m_irq(1), m_rd[1]);
            else passes++;
            hi += o_act[1];
            @(negedge clk);
        end
        checks++;
        if (hi !== 15) $display("FAIL maxlen_width got %0d want 15", hi);
        else passes++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if ({o_act[i], q_act[i], r_act[i]} !== {m_out(i), m_irq(i), m_rd[i]})
                    $display("FAIL random dut%0d cyc=%0d got %b/%b/%h want %b/%b/%h", i, cyc, o_act[i], q_act[i], r_act[i], m_out(i), m_irq(i), m_rd[i]);
                else passes++;
            end
            for (int i = 0; i < 2; i++) begin
                logic [1:0]  a;
                logic [31:0] d;
                a = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) begin
                    if (a == 2'd1)
                        d = ($urandom() & ((i == 0) ? 32'hFF00_0000 : 32'hFFFF_FFF0)) | $urandom_range(0, (i == 0) ? 20 : 15);
                    else if (a == 2'd0)
                        d = ($urandom() & 32'hFFFF_FFFE) | 32'($urandom_range(0, 7) == 0);
                    else
                        d = $urandom();
                    drive(i, 1'b1, a, d);
                end else begin
                    drive(i, 1'b0, a, 32'h0);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_len_change();
        test_level_overlap();
        test_simultaneous();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
